// File: rtl/keypad_entry.sv
// Keypad entry block: scans a 4x4 active-low keypad, debounces complete scans,
// and drives a small editor FSM that commits a BCD time (HHMM) or a plant type.
module keypad_entry #(
    parameter int DEBOUNCE_SCANS = 20,
    parameter int PLANT_MAX      = 9
) (
    input  logic        clk1kHz,
    input  logic        rst,
    input  logic [3:0]  filas,
    output logic [3:0]  columnas,
    output logic [15:0] hora,
    output logic [3:0]  tipoPlanta,
    output logic [1:0]  editando,
    output logic [3:0]  tecla,
    output logic        tecla_valida,
    output logic        error
);

    // Debounce counter only has to reach DEBOUNCE_SCANS-1.
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [3:0] PLANT_MAX_L = 4'(PLANT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HORA   = 2'b01,
        ST_PLANTA = 2'b10
    } state_e;

    // Key code for a (row, column) position on the keypad.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'd1;
            4'h1: k = 4'd2;
            4'h2: k = 4'd3;
            4'h3: k = 4'd10;
            4'h4: k = 4'd4;
            4'h5: k = 4'd5;
            4'h6: k = 4'd6;
            4'h7: k = 4'd11;
            4'h8: k = 4'd7;
            4'h9: k = 4'd8;
            4'hA: k = 4'd9;
            4'hB: k = 4'd12;
            4'hC: k = 4'd14;
            4'hD: k = 4'd0;
            4'hE: k = 4'd15;
            default: k = 4'd13;
        endcase
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer and column scan
    // ------------------------------------------------------------------
    logic [3:0] filas_m_q, filas_s_q;
    logic [3:0] scan_cyc_q;

    // Two-flop synchronizer; idle value is "all rows released".
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            filas_m_q <= 4'hF;
            filas_s_q <= 4'hF;
        end else begin
            filas_m_q <= filas;
            filas_s_q <= filas_m_q;
        end
    end

    // Free-running 16-cycle scan: bits [3:2] select the column, [1:0] the slot cycle.
    always_ff @(posedge clk1kHz) begin
        if (rst) scan_cyc_q <= 4'd0;
        else     scan_cyc_q <= scan_cyc_q + 4'd1;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign columnas[gi] = (scan_cyc_q[3:2] != 2'(gi));
        end
    endgenerate

    logic sample_en, scan_end;
    assign sample_en = (scan_cyc_q[1:0] == 2'b11);
    assign scan_end  = (scan_cyc_q == 4'hF);

    // ------------------------------------------------------------------
    // Per-scan key accumulation
    // ------------------------------------------------------------------
    logic [3:0] row_low;
    logic [2:0] row_cnt;
    logic [1:0] row_idx;
    logic [1:0] hits_q, hits_new;
    logic [3:0] code_q, code_new;
    logic [2:0] hit_sum;
    logic [4:0] scan_res;   // {valid, code}; 0 means no key (none or multi)

    assign row_low = ~filas_s_q;

    // Count low rows in the current column and remember which one was low.
    always_comb begin
        row_cnt = 3'd0;
        row_idx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                row_cnt = row_cnt + 3'd1;
                row_idx = 2'(r);
            end
        end
    end

    // Fold this column's sample into the running scan result (hits saturate at 2 = multi).
    always_comb begin
        hit_sum  = {1'b0, hits_q} + row_cnt;
        hits_new = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_new = (row_cnt == 3'd1) ? key_code(row_idx, scan_cyc_q[3:2]) : code_q;
        scan_res = (hits_new == 2'd1) ? {1'b1, code_new} : 5'b0;
    end

    // Accumulators restart at the end of every complete scan.
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            hits_q <= 2'd0;
            code_q <= 4'd0;
        end else if (sample_en) begin
            if (scan_end) begin
                hits_q <= 2'd0;
                code_q <= 4'd0;
            end else begin
                hits_q <= hits_new;
                code_q <= code_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-level debounce and press detection
    // ------------------------------------------------------------------
    logic [4:0]    prev_q, prev_d, stable_q, stable_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          press_d;
    logic [3:0]    tecla_q;
    logic          tecla_valida_q;

    // Compare each finished scan with the previous one; accept after enough repeats.
    always_comb begin
        prev_d   = prev_q;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (scan_end) begin
            if (scan_res == prev_q)
                db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + CW'(1);
            else
                db_cnt_d = '0;
            prev_d = scan_res;
            if (db_cnt_d == DB_MAX) begin
                stable_d = scan_res;
                press_d  = scan_res[4] && (scan_res != stable_q);
            end
        end
    end

    // Debounce state plus the registered key report.
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            prev_q         <= 5'b0;
            db_cnt_q       <= '0;
            stable_q       <= 5'b0;
            tecla_q        <= 4'd0;
            tecla_valida_q <= 1'b0;
        end else begin
            prev_q         <= prev_d;
            db_cnt_q       <= db_cnt_d;
            stable_q       <= stable_d;
            tecla_valida_q <= press_d;
            if (press_d) tecla_q <= scan_res[3:0];
        end
    end

    assign tecla        = tecla_q;
    assign tecla_valida = tecla_valida_q;

    // ------------------------------------------------------------------
    // Editor FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  ndig_q, ndig_d;
    logic [15:0] hora_q, hora_d;
    logic [3:0]  planta_q, planta_d;
    logic        error_q, error_d;
    logic        hora_ok, planta_ok;

    // Digits are always 0..9, so only HH<=23 and the minutes tens digit need checking.
    assign hora_ok = (ndig_q == 3'd4) && (buf_q[7:4] <= 4'd5) &&
                     ((buf_q[15:12] < 4'd2) || ((buf_q[15:12] == 4'd2) && (buf_q[11:8] <= 4'd3)));
    assign planta_ok = (ndig_q == 3'd1) && (buf_q[3:0] <= PLANT_MAX_L);

    // Next state, edit buffer and commit decisions, driven by accepted key presses.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        ndig_d   = ndig_q;
        hora_d   = hora_q;
        planta_d = planta_q;
        error_d  = 1'b0;
        if (tecla_valida_q) begin
            case (tecla_q)
                4'd10: begin
                    state_d = ST_HORA;
                    buf_d   = 16'h0000;
                    ndig_d  = 3'd0;
                end
                4'd11: begin
                    state_d = ST_PLANTA;
                    buf_d   = 16'h0000;
                    ndig_d  = 3'd0;
                end
                4'd12: state_d = ST_IDLE;
                4'd13: begin
                    case (state_q)
                        ST_HORA: begin
                            if (hora_ok) hora_d = buf_q;
                            else         error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                        ST_PLANTA: begin
                            if (planta_ok) planta_d = buf_q[3:0];
                            else           error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: begin
                    if (tecla_q <= 4'd9) begin
                        if (state_q == ST_HORA && ndig_q < 3'd4) begin
                            case (ndig_q[1:0])
                                2'd0:    buf_d[15:12] = tecla_q;
                                2'd1:    buf_d[11:8]  = tecla_q;
                                2'd2:    buf_d[7:4]   = tecla_q;
                                default: buf_d[3:0]   = tecla_q;
                            endcase
                            ndig_d = ndig_q + 3'd1;
                        end else if (state_q == ST_PLANTA && ndig_q == 3'd0) begin
                            buf_d[3:0] = tecla_q;
                            ndig_d     = 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state, buffer and committed outputs.
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= 16'h0000;
            ndig_q   <= 3'd0;
            hora_q   <= 16'h0000;
            planta_q <= 4'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            ndig_q   <= ndig_d;
            hora_q   <= hora_d;
            planta_q <= planta_d;
            error_q  <= error_d;
        end
    end

    assign hora       = hora_q;
    assign tipoPlanta = planta_q;
    assign editando   = state_q;
    assign error      = error_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives filas from columnas,
// a reference model predicts each key event, and a monitor checks DUT reports.
module tb_keypad_entry;

    localparam int DB   = 3;
    localparam int PMAX = 9;

    logic        clk1kHz = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [15:0] hora;
    logic [3:0]  tipoPlanta;
    logic [1:0]  editando;
    logic [3:0]  tecla;
    logic        tecla_valida;
    logic        error;

    keypad_entry #(.DEBOUNCE_SCANS(DB), .PLANT_MAX(PMAX)) dut (
        .clk1kHz      (clk1kHz),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .hora         (hora),
        .tipoPlanta   (tipoPlanta),
        .editando     (editando),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .error        (error)
    );

    always #5 clk1kHz = ~clk1kHz;

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] keys_mask = 16'h0000;
    int key_at [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Passive keypad: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_mask[r*4+c] && columnas[c] == 1'b0) filas[r] = 1'b0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          tecla;
        logic [15:0] hora;
        int          planta;
        int          edit;
        bit          err;
    } exp_t;

    exp_t        expq[$];
    int          hist[$];
    int          stable;
    int          st;
    int          digs[$];
    logic [15:0] m_hora;
    int          m_planta;

    function automatic logic [15:0] mask_of(input int code);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (key_at[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(-1);
        stable = -1;
        st     = 0;
        digs.delete();
        m_hora   = 16'h0000;
        m_planta = 0;
    endtask

    task automatic model_key(input int k);
        exp_t e;
        bit   err;
        err = 1'b0;
        if (k == 10) begin
            st = 1; digs.delete();
        end else if (k == 11) begin
            st = 2; digs.delete();
        end else if (k == 12) begin
            st = 0;
        end else if (k == 13) begin
            if (st == 1) begin
                if (digs.size() == 4 && digs[0]*10 + digs[1] <= 23 && digs[2]*10 + digs[3] <= 59)
                    m_hora = {4'(digs[0]), 4'(digs[1]), 4'(digs[2]), 4'(digs[3])};
                else
                    err = 1'b1;
                st = 0;
            end else if (st == 2) begin
                if (digs.size() == 1 && digs[0] <= PMAX) m_planta = digs[0];
                else                                     err = 1'b1;
                st = 0;
            end
        end else if (k <= 9) begin
            if (st == 1 && digs.size() < 4) digs.push_back(k);
            if (st == 2 && digs.size() < 1) digs.push_back(k);
        end
        e.tecla  = k;
        e.hora   = m_hora;
        e.planta = m_planta;
        e.edit   = st;
        e.err    = err;
        expq.push_back(e);
    endtask

    // A key state is accepted once the last DB scans all agree.
    task automatic model_scan(input logic [15:0] mask);
        int  res;
        bit  same;
        res = -1;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) res = key_at[i];
        hist.push_back(res);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != res) same = 1'b0;
            if (same) begin
                if (res != -1 && res != stable) model_key(res);
                stable = res;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // One complete 16-cycle scan with a fixed key set, starting at cycle 0 of the scan.
    task automatic do_scan(input logic [15:0] mask);
        logic [3:0] exp_col;
        keys_mask = mask;
        model_scan(mask);
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            check("columnas", columnas, exp_col);
            @(negedge clk1kHz);
        end
    endtask

    task automatic press(input int code, input int hold, input int rel);
        logic [15:0] m;
        m = mask_of(code);
        repeat (hold) do_scan(m);
        repeat (rel) do_scan(16'h0000);
    endtask

    task automatic key(input int code);
        press(code, 4, 4);
    endtask

    task automatic check_reset_outputs();
        check("rst_columnas", columnas, 4'b1110);
        check("rst_hora", hora, 16'h0000);
        check("rst_tipoPlanta", tipoPlanta, 4'd0);
        check("rst_editando", editando, 2'b00);
        check("rst_tecla", tecla, 4'd0);
        check("rst_tecla_valida", tecla_valida, 1'b0);
        check("rst_error", error, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        keys_mask = 16'h0000;
        @(negedge clk1kHz);
        check_reset_outputs();
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk1kHz);
            if (pend) begin
                check("hora", hora, cur.hora);
                check("tipoPlanta", tipoPlanta, 32'(cur.planta));
                check("editando", editando, 32'(cur.edit));
                check("error", error, cur.err);
                pend = 1'b0;
            end else if (error === 1'b1) begin
                check("error_spurious", error, 1'b0);
            end
            if (tecla_valida === 1'b1) begin
                if (expq.size() == 0) begin
                    check("tecla_valida_unexpected", tecla_valida, 1'b0);
                end else begin
                    cur = expq.pop_front();
                    check("tecla", tecla, 32'(cur.tecla));
                    pend = 1'b1;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [15:0] m;
        int          c, i, j;
        model_reset();
        repeat (3) @(negedge clk1kHz);
        check_reset_outputs();
        rst = 1'b0;
        repeat (4) do_scan(16'h0000);

        // Basic time entry with long holds and releases.
        press(10, 6, 6); press(1, 6, 6); press(2, 6, 6);
        press(3, 6, 6);  press(4, 6, 6); press(13, 6, 6);

        // Out-of-range hour is rejected.
        key(10); key(2); key(5); key(0); key(0); key(13);

        // Plant type commit, then cancelled edit.
        key(11); key(7); key(13);
        key(11); key(3); key(12);

        // Two keys at once never report; the lone key afterwards does.
        m = mask_of(5) | mask_of(9);
        repeat (10) do_scan(m);
        repeat (4) do_scan(16'h0000);
        key(5);

        // Bouncing key settles into a single press.
        m = mask_of(8);
        for (int k = 0; k < 10; k++) do_scan((k % 2 == 0) ? m : 16'h0000);
        repeat (5) do_scan(m);
        repeat (4) do_scan(16'h0000);

        // Reset in the middle of an entry, then a fresh entry.
        key(10); key(1); key(2);
        do_reset();
        key(10); key(0); key(9); key(3); key(0); key(13);

        // Boundary commits.
        key(10); key(2); key(3); key(5); key(9); key(13);
        key(10); key(2); key(4); key(0); key(0); key(13);
        key(10); key(1); key(9); key(6); key(0); key(13);
        key(10); key(1); key(2); key(13);
        key(10); key(1); key(2); key(3); key(4); key(5); key(6); key(13);
        key(11); key(9); key(13);
        key(11); key(13);
        key(11); key(4); key(5); key(13);
        key(10); key(1); key(11); key(2); key(13);
        key(13); key(1); key(14); key(15);
        key(10); key(14); key(1); key(15); key(2); key(3); key(4); key(13);

        // Randomized presses, short glitches, multi-key chords and direct key changes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                i = $urandom_range(0, 15);
                j = (i + $urandom_range(1, 15)) % 16;
                m = '0;
                m[i] = 1'b1;
                m[j] = 1'b1;
                repeat ($urandom_range(1, 6)) do_scan(m);
                repeat ($urandom_range(1, 5)) do_scan(16'h0000);
            end else begin
                c = $urandom_range(0, 19);
                if (c > 15) c = (c == 16) ? 10 : 13;
                press(c, $urandom_range(1, 6), $urandom_range(1, 5));
            end
        end

        repeat (4) do_scan(16'h0000);
        check("pending_events", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEBOUNCE_SCANS, default 20: consecutive identical complete scans needed to accept a key state.
REQ-002 Parameter PLANT_MAX, default 9: highest accepted tipoPlanta value.
REQ-003 clk1kHz  in  1: single clock; all logic on rising edge.
REQ-004 rst  in  1: reset; synchronous and active-high.
REQ-005 filas  in  4: keypad rows, active-low, externally pulled up, asynchronous to clk1kHz.
REQ-006 columnas  out  4: keypad column drive, active-low one-hot.
REQ-007 hora  out  16: committed time as BCD HHMM (hora[15:12] = tens of hours).
REQ-008 tipoPlanta  out  4: committed plant type, binary 0..PLANT_MAX.
REQ-009 editando  out  2: 00 idle, 01 entering hora, 10 entering tipoPlanta.
REQ-010 tecla  out  4: last accepted key code; tecla_valida  out  1: one-cycle pulse per accepted press.
REQ-011 error  out  1: one-cycle pulse when a commit is rejected.

Function
REQ-012 Key map by (row,col): r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D; codes 0-9 are the digits, A=10, B=11, C=12, D=13, *=14, #=15.
REQ-013 filas is passed through a 2-flop synchronizer before use.
REQ-014 Each column is driven low for 4 cycles, in order c0,c1,c2,c3, wrapping to c0; one full scan takes 16 cycles.
REQ-015 Synchronized rows are sampled on the 4th cycle of each column slot.
REQ-016 A scan result is "none" when no row is low in any column, or "multi" when more than one key is low in total; both of these mean no key.
REQ-017 A debounce counter compares each scan result with the previous scan result.
REQ-018 The counter increments when the two results are equal and clears to 0 when they differ.
REQ-019 The stable state updates when the counter reaches DEBOUNCE_SCANS-1.
REQ-020 A press event fires when the stable state changes from no-key to a single key.
REQ-021 On a press event, tecla and tecla_valida are updated in the cycle after the scan completes.
REQ-022 Holding a key produces exactly one event; a new event requires release to stable no-key, or a change to a different stable key.
REQ-023 FSM states are IDLE, HORA and PLANTA; editando encodes the current state.
REQ-024 Key A in any state: go to HORA with an empty 4-digit buffer.
REQ-025 Key B in any state: go to PLANTA with an empty 1-digit buffer.
REQ-026 Key C in HORA or PLANTA: return to IDLE; committed outputs unchanged.
REQ-027 HORA digits are stored left to right; digits beyond the 4th are ignored.
REQ-028 PLANTA stores the first digit only; later digits are ignored.
REQ-029 Key D in HORA commits the buffer to hora only if 4 digits are present, HH<=23 and MM<=59.
REQ-030 Key D in PLANTA commits tipoPlanta only if 1 digit is present and it is <=PLANT_MAX.
REQ-031 Committed values are visible one cycle after tecla_valida for the D key.
REQ-032 A failed commit pulses error in that same cycle, leaves outputs unchanged, and returns to IDLE.
REQ-033 Any exit from HORA or PLANTA returns to IDLE.
REQ-034 In IDLE, digit, C, D, * and # keys are ignored; * and # are ignored in every state.
REQ-035 tecla_valida pulses for every accepted press, including keys the FSM ignores.

Reset
REQ-036 While rst=1 at a clock edge: columnas=4'b1110, hora=16'h0000, tipoPlanta=0, editando=00, tecla=0.
REQ-037 While rst=1 at a clock edge: tecla_valida=0 and error=0.
REQ-038 While rst=1 at a clock edge: synchronizers, scan counters, debounce counter and buffers are cleared, and the stable state is no-key.
REQ-039 Reset asserted mid-entry discards the partial buffer.
REQ-040 After reset deasserts, the scan restarts at c0.

Verification (DEBOUNCE_SCANS=3 on the bench)
REQ-041 Press keys A,1,2,3,4,D, each held 6 scans with 6 scans released between -> 6 tecla_valida pulses, editando=01 after A, hora=16'h1234 and editando=00 after D.
REQ-042 Enter A,2,5,0,0,D -> error pulses once, hora keeps its previous value, editando=00.
REQ-043 Enter B,7,D -> tipoPlanta=7; then B,3,C -> tipoPlanta stays 7.
REQ-044 Hold keys 5 and 9 together for 10 scans -> no tecla_valida; release both and press 5 alone -> one event with tecla=5.
REQ-045 Press key 8 with bounce glitches every 2 scans for 10 scans, then stable -> exactly one event, after 3 stable scans.
REQ-046 Enter A,1,2, then assert rst for 1 cycle -> all outputs at reset values; then A,0,9,3,0,D -> hora=16'h0930.
